// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types and constants
package rv32i_types;

  localparam int PIPE_OPS = 2;

  // Metadata carried alongside the operands from decode into execute.
  typedef struct packed {
    logic [9:0]  pc_plus4;
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        is_branch;
    logic [1:0]  pht_idx;
    logic        pc_taken;
    logic        pht_prediction;
  } pipe_meta_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - load-enable payload register with async active-low clear
module pipe_payload_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - elastic ID/EX stage register with 2-entry skid buffer, flush and head overwrite
module id_ex_pipe_stage
  import rv32i_types::*;
#(
  parameter int CTRL_W  = 32,
  parameter int META_W  = $bits(pipe_meta_t),
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = PIPE_OPS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [META_W-1:0]         in_meta,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [META_W-1:0]         out_meta,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  input  logic                      flush,
  input  logic [NUM_OPS-1:0]        ow_en,
  input  logic [NUM_OPS*DATA_W-1:0] ow_data,
  output logic [1:0]                occupancy
);

  localparam int CM_W  = CTRL_W + META_W;
  localparam int OPS_W = NUM_OPS * DATA_W;
  localparam int ENT_W = CM_W + OPS_W;

  logic             head_valid, skid_valid;
  logic             head_valid_d, skid_valid_d;
  logic             in_fire, out_fire;
  logic             head_load, skid_load, ow_act;
  logic [ENT_W-1:0] in_ent, skid_q, head_src;
  logic [CM_W-1:0]  head_cm;
  logic [OPS_W-1:0] head_ops, head_ops_d;
  logic [NUM_OPS-1:0] lane_load;

  assign in_fire  = in_valid & ~skid_valid;
  assign out_fire = head_valid & out_ready;
  assign in_ent   = {in_ctrl, in_meta, in_ops};
  // The head refills from the skid entry whenever one is waiting, keeping FIFO order.
  assign head_src = skid_valid ? skid_q : in_ent;

  always_comb begin
    head_valid_d = head_valid;
    skid_valid_d = skid_valid;
    head_load    = 1'b0;
    skid_load    = 1'b0;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid) begin
      head_valid_d = in_fire;
      head_load    = in_fire;
    end else if (!skid_valid) begin
      if (out_fire) begin
        head_valid_d = in_fire;
        head_load    = in_fire;
      end else if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_load    = 1'b1;
      end
    end else if (out_fire) begin
      skid_valid_d = 1'b0;
      head_load    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      head_valid <= head_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  // Overwrite only lands on a head that stays put; never mutually active with head_load.
  assign ow_act = head_valid & ~out_fire & ~flush;

  pipe_payload_reg #(.W(ENT_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_ent),
    .q     (skid_q)
  );

  pipe_payload_reg #(.W(CM_W)) u_head_cm (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (head_load),
    .d     (head_src[ENT_W-1:OPS_W]),
    .q     (head_cm)
  );

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_lane
    assign lane_load[i] = head_load | (ow_act & ow_en[i]);
    assign head_ops_d[i*DATA_W +: DATA_W] =
      head_load ? head_src[i*DATA_W +: DATA_W] : ow_data[i*DATA_W +: DATA_W];

    pipe_payload_reg #(.W(DATA_W)) u_head_op (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load[i]),
      .d     (head_ops_d[i*DATA_W +: DATA_W]),
      .q     (head_ops[i*DATA_W +: DATA_W])
    );
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = head_valid;
  assign out_ctrl  = head_cm[CM_W-1:META_W];
  assign out_meta  = head_cm[META_W-1:0];
  assign out_ops   = head_ops;
  assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb/tb_id_ex_pipe_stage.sv - self-checking bench for id_ex_pipe_stage
module tb_id_ex_pipe_stage;

  localparam int CTRL_W = 32;
  localparam int META_W = 42;
  localparam int DATA_W = 32;
  localparam int NUM_OPS = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [CTRL_W-1:0]         in_ctrl = '0;
  logic [META_W-1:0]         in_meta = '0;
  logic [NUM_OPS*DATA_W-1:0] in_ops = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [CTRL_W-1:0]         out_ctrl;
  logic [META_W-1:0]         out_meta;
  logic [NUM_OPS*DATA_W-1:0] out_ops;
  logic                      flush = 1'b0;
  logic [NUM_OPS-1:0]        ow_en = '0;
  logic [NUM_OPS*DATA_W-1:0] ow_data = '0;
  logic [1:0]                occupancy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_meta(in_meta), .in_ops(in_ops),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_meta(out_meta), .out_ops(out_ops),
    .flush(flush), .ow_en(ow_en), .ow_data(ow_data),
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        iv;
    bit [31:0] ctrl;
    bit [31:0] op0;
    bit [31:0] op1;
    bit        ordy;
    bit        fl;
    bit [1:0]  owen;
    bit [31:0] owd1;
    bit        ev;
    bit        er;
    bit [1:0]  eocc;
    bit [31:0] ectrl;
    bit [31:0] eop0;
    bit [31:0] eop1;
  } vec_t;

  typedef struct {
    logic [CTRL_W-1:0]         ctrl;
    logic [META_W-1:0]         meta;
    logic [NUM_OPS*DATA_W-1:0] ops;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];

  initial begin
    // iv ctrl op0 op1 ordy fl owen owd1 | ev er occ ctrl op0 op1
    tbl.push_back('{1, 32'h13, 5, 0,     1, 0, 2'b00, 0,      1, 1, 1, 32'h13, 5, 0});
    tbl.push_back('{0, 0,      0, 0,     1, 0, 2'b00, 0,      0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 32'hA,  1, 32'h10, 0, 0, 2'b00, 0,     1, 1, 1, 32'hA, 1, 32'h10});
    tbl.push_back('{1, 32'hB,  2, 32'h20, 0, 0, 2'b00, 0,     1, 0, 2, 32'hA, 1, 32'h10});
    tbl.push_back('{1, 32'hC,  3, 32'h30, 0, 0, 2'b00, 0,     1, 0, 2, 32'hA, 1, 32'h10});
    tbl.push_back('{0, 0,      0, 0,     0, 0, 2'b10, 32'hAB, 1, 0, 2, 32'hA, 1, 32'hAB});
    tbl.push_back('{0, 0,      0, 0,     1, 0, 2'b10, 32'hCD, 1, 1, 1, 32'hB, 2, 32'h20});
    tbl.push_back('{0, 0,      0, 0,     1, 0, 2'b00, 0,      0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 32'hD,  4, 32'h40, 0, 0, 2'b00, 0,     1, 1, 1, 32'hD, 4, 32'h40});
    tbl.push_back('{1, 32'hE,  5, 32'h50, 0, 0, 2'b00, 0,     1, 0, 2, 32'hD, 4, 32'h40});
    tbl.push_back('{1, 32'hF,  6, 32'h60, 0, 1, 2'b00, 0,     0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 32'h1A, 7, 32'h70, 0, 0, 2'b00, 0,     1, 1, 1, 32'h1A, 7, 32'h70});
    tbl.push_back('{1, 32'h1B, 8, 32'h80, 1, 1, 2'b01, 32'h1, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0,      0, 0,     1, 0, 2'b00, 0,      0, 1, 0, 0, 0, 0});

    rst_n = 1'b0;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_out_ops", 64'(out_ops), 64'd0);
    chk("reset_out_ctrl", 64'(out_ctrl), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[k]) begin
      in_valid  = tbl[k].iv;
      in_ctrl   = tbl[k].ctrl;
      in_meta   = 42'(k);
      in_ops    = {tbl[k].op1, tbl[k].op0};
      out_ready = tbl[k].ordy;
      flush     = tbl[k].fl;
      ow_en     = tbl[k].owen;
      ow_data   = {tbl[k].owd1, 32'hDEAD0000};
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].ev));
      chk($sformatf("vec%0d_in_ready", k), 64'(in_ready), 64'(tbl[k].er));
      chk($sformatf("vec%0d_occupancy", k), 64'(occupancy), 64'(tbl[k].eocc));
      if (tbl[k].ev) begin
        chk($sformatf("vec%0d_ctrl", k), 64'(out_ctrl), 64'(tbl[k].ectrl));
        chk($sformatf("vec%0d_op0", k), 64'(out_ops[31:0]), 64'(tbl[k].eop0));
        chk($sformatf("vec%0d_op1", k), 64'(out_ops[63:32]), 64'(tbl[k].eop1));
      end
    end
    flush = 1'b0;
    ow_en = '0;

    // back-to-back streaming with out_ready held high
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_ctrl   = 32'h100 + 32'(i);
      in_ops    = {32'h0, 32'(i)};
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream%0d_op0", i), 64'(out_ops[31:0]), 64'(i));
      chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("stream_drain_occ", 64'(occupancy), 64'd0);

    // fill, then async reset between edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_before_areset", 64'(occupancy), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd1);
    chk("areset_occupancy", 64'(occupancy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // random traffic against a queue model of a depth-2 FIFO
    mq = {};
    for (int c = 0; c < 600; c++) begin
      bit inf, outf;
      ent_t e;
      chk("rnd_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("rnd_in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("rnd_occupancy", 64'(occupancy), 64'(mq.size()));
      if (mq.size() > 0) begin
        chk("rnd_ctrl", 64'(out_ctrl), 64'(mq[0].ctrl));
        chk("rnd_meta", 64'(out_meta), 64'(mq[0].meta));
        chk("rnd_ops", 64'(out_ops), 64'(mq[0].ops));
      end
      in_valid  = ($urandom_range(0, 9) < 6);
      in_ctrl   = $urandom;
      in_meta   = {10'($urandom), $urandom};
      in_ops    = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      ow_en     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      ow_data   = {$urandom, $urandom};
      inf  = in_valid && (mq.size() < 2);
      outf = out_ready && (mq.size() > 0);
      if (flush) begin
        mq = {};
      end else begin
        if (outf) begin
          void'(mq.pop_front());
        end else if (mq.size() > 0) begin
          for (int l = 0; l < NUM_OPS; l++)
            if (ow_en[l]) mq[0].ops[l*DATA_W +: DATA_W] = ow_data[l*DATA_W +: DATA_W];
        end
        if (inf) begin
          e.ctrl = in_ctrl;
          e.meta = in_meta;
          e.ops  = in_ops;
          mq.push_back(e);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised, elastic successor to the fixed ID/EX stage register.
- Carries a generic payload between pipeline stages: control word, metadata bus, and NUM_OPS operand lanes.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure never creates a combinational ready path.
- Supports a synchronous flush, and per-lane operand overwrite of the head entry, which the forwarding unit uses for late-arriving results.

Parameters:
- CTRL_W, 32, width of control word field.
- META_W, 42, width of opaque metadata (pc_plus4, imm, reg indices, branch-prediction info, packed by instantiator).
- DATA_W, 32, width of each operand lane.
- NUM_OPS, 2, number of operand lanes (min 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept payload; registered.
- in_ctrl  in  CTRL_W  control word.
- in_meta  in  META_W  metadata.
- in_ops  in  NUM_OPS*DATA_W  operand lanes, lane i at [i*DATA_W +: DATA_W].
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_ctrl  out  CTRL_W  head control word.
- out_meta  out  META_W  head metadata.
- out_ops  out  NUM_OPS*DATA_W  head operand lanes.
- flush  in  1  kill all held entries.
- ow_en  in  NUM_OPS  per-lane overwrite enable for head entry.
- ow_data  in  NUM_OPS*DATA_W  overwrite values.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Reset (async assert, rst_n=0): head_valid=0, skid_valid=0, out_valid=0, in_ready=1, occupancy=0, all payload registers 0.
- Release is synchronous to clk.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs driven directly from head registers; zero combinational path from inputs to outputs.
- in_ready = !skid_valid (registered state).
- State is encoded by {skid_valid, head_valid}:
  - EMPTY: in_fire -> ONE, head <= in.
  - ONE, in_fire & out_fire -> ONE, head <= in.
  - ONE, in_fire & !out_fire -> FULL, skid <= in.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> hold.
  - FULL (in_ready=0): out_fire -> ONE, head <= skid; otherwise hold.
- Ordering is strictly FIFO. Latency is 1 cycle from in_fire to out_valid when empty.
- Throughput is 1/cycle with out_ready held high.
- Flush: next state EMPTY regardless of in_fire/out_fire in the same cycle.
  - An incoming transfer in the flush cycle is discarded.
  - Payload registers need not clear.
  - in_ready=1 on the following cycle.
- Overwrite: for each lane i with ow_en[i]=1, head op lane i <= ow_data lane i, only when head_valid & !out_fire & !flush.
  - Overwrite is ignored when out_fire=1 (consumer already sampled) or the head is empty.
  - Overwrite never affects the skid entry or in-flight input.
  - On FULL & out_fire the skid entry moves to head unmodified.
- occupancy = head_valid + skid_valid.
- Illegal input changes while in_valid & !in_ready are tolerated; values are unused.
- Async reset mid-operation drops all entries immediately.

Decomposition:
- Shared package rv32i_types gains:
  - constant PIPE_OPS = 2;
  - typedef pipe_meta_t (packed struct: pc_plus4, imm, rs1, rs2, rd, is_branch, pht_idx, pc_taken, pht_prediction);
  - META_W defaults to $bits(pipe_meta_t).
- One natural sub-module: pipe_payload_reg, a width-parametrised load-enable register with async active-low clear.
  - Instantiated for head and skid.
  - Operand lanes in head use per-lane load selects.

Test Plan:
- Reset then single push: rst_n=0->1, in_valid=1 ctrl=0x13 op0=5, out_ready=1 -> out_valid=1 next cycle with ctrl 0x13, op0=5; occupancy 1 then 0.
- Backpressure fill: out_ready=0, push A, B, C on consecutive cycles -> A held at head, B in skid, in_ready=0 after B, C not accepted; occupancy=2; raise out_ready -> A, B emerge in order, then in_ready=1.
- Streaming: out_ready=1, 8 back-to-back pushes op0=0..7 -> out_valid continuously after first, values 0..7 in order, in_ready never drops.
- Flush with concurrent push: FULL state, flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, occupancy=0, in_ready=1; pushed item never appears.
- Overwrite: head op1=0x10, out_ready=0, ow_en=2'b10 ow_data lane1=0xAB -> next cycle out_ops lane1=0xAB, lane0 unchanged; repeat with out_ready=1 same cycle -> old value consumed, overwrite dropped, skid entry unmodified.
- Async reset mid-stream: assert rst_n=0 between clock edges while FULL -> out_valid=0, in_ready=1, occupancy=0 immediately, without waiting for clk.
